// File: rtl/ifid_pkg.sv
// ifid_pkg: shared constants and entry type for the IF/ID queue.
// NOP_INSTR_DEFAULT is what Decode sees whenever no real entry exists;
// HALT_INSTR exists only so assertions can prove the queue never emits it
// as a bubble.
package ifid_pkg;

    localparam int          INSTR_W_DEFAULT   = 16;
    localparam int          PC_W_DEFAULT      = 16;
    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h1800;
    localparam logic [15:0] HALT_INSTR        = 16'h0000;

    // One fetched slot as stored between Fetch and Decode
    typedef struct packed {
        logic [INSTR_W_DEFAULT-1:0] instr;
        logic [PC_W_DEFAULT-1:0]    pcinc;
    } ifid_entry_t;

endpackage

// File: rtl/ifid_entry_ram.sv
// ifid_entry_ram: DEPTH x WIDTH register array holding queued {instr, pcinc}
// entries. Synchronous write, asynchronous read. Storage is deliberately not
// reset: validity is tracked by the occupancy count in ifid_queue, exactly
// like a non-reset instruction register.
module ifid_entry_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one entry per cycle at the write pointer
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port is combinational so the head is visible the cycle after its write
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ifid_queue.sv
// ifid_queue: DEPTH-entry FIFO between Fetch and Decode, replacing the single
// IF/ID register. Fetch keeps running while Decode stalls; flush empties the
// queue and shows a NOP bubble. Reset shows NOP, never HALT.
// Optional feature macro: IFID_BYPASS_EN -- when the queue is empty, the
// incoming entry drives Decode combinationally (zero-latency fetch-to-decode).
// Without it, every entry spends at least one cycle in storage.
// DEPTH must be >= 1; it need not be a power of two (pointers wrap explicitly).
module ifid_queue
    import ifid_pkg::*;
#(
    parameter int                 INSTR_W   = 16,
    parameter int                 PC_W      = 16,
    parameter int                 DEPTH     = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic [PC_W-1:0]            in_pcinc,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [PC_W-1:0]            out_pcinc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_W = INSTR_W + PC_W;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] head;
    logic               empty;
    logic               full;
    logic               bypass;
    logic               push;
    logic               pop;
    logic               wr_en;
    logic               rd_adv;

    // Advance a pointer modulo DEPTH without requiring a power-of-two depth
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // in_ready depends only on registered occupancy (and reset): no path from
    // Decode's out_ready back to Fetch.
    assign in_ready = ~rst & ~full;

`ifdef IFID_BYPASS_EN
    assign bypass = empty & in_valid & ~flush & ~rst;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = ~rst & (~empty | bypass);

    // Flush dominates any same-cycle handshake
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // A bypassed entry consumed in the same cycle never touches storage;
    // a bypassed entry Decode refuses is written like any other push.
    assign wr_en  = push & ~(bypass & out_ready);
    assign rd_adv = pop & ~empty;

    ifid_entry_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data ({in_instr, in_pcinc}),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Pointer and occupancy update; reset beats flush, flush beats push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_adv) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_adv);
        end
    end

    // Output mux: stored head first, then bypass, otherwise a NOP bubble
    always_comb begin
        out_instr = NOP_INSTR;
        out_pcinc = '0;
        if (!rst) begin
            if (!empty) begin
                out_instr = head[ENTRY_W-1:PC_W];
                out_pcinc = head[PC_W-1:0];
            end else if (bypass) begin
                out_instr = in_instr;
                out_pcinc = in_pcinc;
            end
        end
    end

    // A bubble must never look like HALT, on reset, flush or plain empty
    a_no_halt_bubble: assert property (@(posedge clk)
        !out_valid |-> (out_instr != INSTR_W'(HALT_INSTR)));

    // Fetch is held off for the whole reset
    a_rst_not_ready: assert property (@(posedge clk) rst |-> !in_ready);

endmodule

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Holds up to DEPTH fetched {instruction, PC+2} pairs between Fetch and Decode, so Fetch can keep running while Decode stalls for a few cycles.
- Flush discards every buffered entry and presents a NOP bubble to Decode.
- Reset presents a NOP, never a HALT.

Parameters:
INSTR_W, 16, instruction width in bits
PC_W, 16, PC+2 width in bits
DEPTH, 2, number of entries; must be >= 1 and need not be a power of two
NOP_INSTR, 16'h1800, instruction driven to Decode when no valid entry exists

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  Fetch presents an entry this cycle
in_instr  in  INSTR_W  fetched instruction
in_pcinc  in  PC_W  fetched PC+2
in_ready  out  1  queue can accept an entry; equals ~full, registered-state only
flush  in  1  branch/jump mispredict; discard all entries
out_valid  out  1  out_instr/out_pcinc hold a real entry
out_instr  out  INSTR_W  head instruction, or NOP_INSTR
out_pcinc  out  PC_W  head PC+2, or 0 when not valid
out_ready  in  1  Decode consumes the head this cycle (inverse of the stall)
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset: on the clk edge with rst=1, count←0 and both pointers←0; storage contents are don't-care.
- While rst=1, out_instr=NOP_INSTR combinationally, and out_valid=0, out_pcinc=0, in_ready=0.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- Push and pop in the same cycle is legal; count is unchanged.
- Pointer wrap: wr_ptr and rd_ptr advance modulo DEPTH (explicit compare to DEPTH-1, then 0).
- count = count + push - pop, kept in $clog2(DEPTH+1) bits.
- Full: count==DEPTH, so in_ready=0. in_ready does not depend on out_ready; there is no comb path from Decode to Fetch.
- Empty: count==0, so out_valid=0, out_instr=NOP_INSTR, out_pcinc=0.
- Latency: an entry pushed at edge N is visible on the outputs after edge N (one cycle), unless IFID_BYPASS_EN applies.
- Flush: on an edge with flush=1, count←0 and rd_ptr←wr_ptr.
  - flush dominates any same-cycle push or pop.
  - The next cycle shows NOP_INSTR with out_valid=0.
- Reset dominates flush.
- Data ordering is strict FIFO.
- Outputs are held stable while out_ready=0.

Optional Feature:
- Macro: IFID_BYPASS_EN.
- Defined: when count==0, in_valid=1, flush=0 and rst=0, in_instr/in_pcinc drive the outputs combinationally with out_valid=1.
  - If out_ready=1 in that cycle, the entry is consumed without being written, and count stays 0.
  - If out_ready=0, it is written normally.
  - Gives zero-latency fetch-to-decode.
- Undefined: outputs come only from storage, giving the fixed one-cycle latency above.

Decomposition:
- Package ifid_pkg:
  - NOP_INSTR default (16'h1800)
  - HALT_INSTR (16'h0000), referenced only by assertions: the queue must never emit HALT_INSTR on reset or flush
  - a typedef for the {instr, pcinc} entry struct
- One sub-module: ifid_entry_ram.
  - DEPTH×(INSTR_W+PC_W) register array.
  - Synchronous write port, asynchronous read port.
  - No reset on storage, matching the non-reset instruction register practice.
- Pointers, count and output muxing live in ifid_queue.

Test Plan:
- Reset: assert rst 3 cycles with in_valid=1 and in_instr=16'hABCD → out_instr=16'h1800, out_valid=0, count=0, in_ready=0. Release → in_ready=1.
- Fill/stall: out_ready=0, push instructions 16'h1111 then 16'h2222 → count=2, in_ready=0. A third push of 16'h3333 is dropped, and Fetch must hold it.
- Drain order: from full, out_ready=1 for 2 cycles → out_instr=16'h1111 then 16'h2222, then 16'h1800 with out_valid=0.
- Simultaneous push/pop at count=1 → count stays 1. Verify pointer wrap over 5 entries with DEPTH=3 (sequence 1..5 emerges in order).
- Flush with push in the same cycle at count=2 → next cycle count=0, out_instr=16'h1800. The pushed entry is discarded.
- Bypass (IFID_BYPASS_EN defined): empty queue, in_instr=16'h4444, out_ready=1 → out_instr=16'h4444 the same cycle, count stays 0. Undefined build → 16'h4444 appears one cycle later.
